// File: rtl/axi_rsp_arbiter.sv
// Round-robin, packet-atomic merge of NUM_SRC AXI-Stream response sources.
// Define RSP_TIMEOUT_EN to build the idle-source watchdog (error beat + FLUSH).
`timescale 1ns/1ps
module axi_rsp_arbiter #(
    parameter int NUM_SRC        = 4,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                  axi_tclk,
    input  logic                  axi_tresetn,
    input  logic                  enable_arb,
    input  logic [NUM_SRC*32-1:0] s_axis_tdata,
    input  logic [NUM_SRC*32-1:0] s_axis_tuser,
    input  logic [NUM_SRC-1:0]    s_axis_tvalid,
    input  logic [NUM_SRC-1:0]    s_axis_tlast,
    output logic [NUM_SRC-1:0]    s_axis_tready,
    output logic [31:0]           m_axis_tdata,
    output logic [31:0]           m_axis_tuser,
    output logic                  m_axis_tvalid,
    output logic                  m_axis_tlast,
    output logic [3:0]            m_axis_tdest,
    input  logic                  m_axis_tready,
    output logic [2:0]            grant_idx,
    output logic                  busy,
    output logic                  timeout_pulse
);

    localparam int          IW       = $clog2(NUM_SRC);
    localparam logic [31:0] ERR_WORD = 32'h45525252;

    if (NUM_SRC < 2 || NUM_SRC > 8 || TIMEOUT_CYCLES < 2 || TIMEOUT_CYCLES > 65535) begin : g_param_check
        $error("axi_rsp_arbiter: parameter out of legal range");
    end

    typedef enum logic [1:0] {IDLE, ARB, XFER, FLUSH} state_t;

    state_t          state, state_next;
    logic [IW-1:0]   grant, rr_ptr, pick, cand;
    logic            pick_valid;
    logic            any_req, out_free;
    logic            g_valid, g_last, g_ready, g_accept, xfer_accept;
    logic [31:0]     g_data, g_user;
    logic            timeout_fire;

    assign any_req     = |s_axis_tvalid;
    assign out_free    = !m_axis_tvalid || m_axis_tready;
    assign g_valid     = s_axis_tvalid[grant];
    assign g_last      = s_axis_tlast[grant];
    assign g_data      = s_axis_tdata[int'(grant)*32 +: 32];
    assign g_user      = s_axis_tuser[int'(grant)*32 +: 32];
    assign g_ready     = (state == XFER) ? out_free : (state == FLUSH);
    assign g_accept    = g_valid && g_ready;
    assign xfer_accept = g_accept && (state == XFER);
    assign grant_idx   = 3'(grant);
    assign busy        = (state != IDLE);

    // First requesting source at or after the round-robin pointer, wrapping modulo NUM_SRC
    always_comb begin
        pick       = '0;
        pick_valid = 1'b0;
        cand       = '0;
        for (int k = 0; k < NUM_SRC; k++) begin
            cand = IW'((int'(rr_ptr) + k) % NUM_SRC);
            if (!pick_valid && s_axis_tvalid[cand]) begin
                pick_valid = 1'b1;
                pick       = cand;
            end
        end
    end

`ifdef RSP_TIMEOUT_EN
    localparam logic [15:0] CNT_LAST = 16'(TIMEOUT_CYCLES - 1);
    logic [15:0] idle_cnt;

    // The error beat waits for a free output slot so a stalled beat is never overwritten
    assign timeout_fire = (state == XFER) && !g_valid && (idle_cnt == CNT_LAST) && out_free;

    always_ff @(posedge axi_tclk or negedge axi_tresetn) begin
        if (!axi_tresetn)
            idle_cnt <= '0;
        else if (state != XFER || xfer_accept)
            idle_cnt <= '0;
        else if (!g_valid && idle_cnt != CNT_LAST)
            idle_cnt <= idle_cnt + 16'd1;
    end
`else
    assign timeout_fire = 1'b0;
`endif

    always_ff @(posedge axi_tclk or negedge axi_tresetn) begin
        if (!axi_tresetn)
            state <= IDLE;
        else
            state <= state_next;
    end

    always_comb begin
        state_next           = state;
        s_axis_tready        = '0;
        s_axis_tready[grant] = g_ready;
        case (state)
            IDLE:    if (enable_arb && any_req) state_next = ARB;
            ARB:     state_next = (enable_arb && pick_valid) ? XFER : IDLE;
            XFER: begin
                if (timeout_fire)
                    state_next = FLUSH;
                else if (xfer_accept && g_last)
                    state_next = enable_arb ? ARB : IDLE;
            end
            FLUSH:   if (g_accept && g_last) state_next = ARB;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge axi_tclk or negedge axi_tresetn) begin
        if (!axi_tresetn) begin
            grant  <= '0;
            rr_ptr <= '0;
        end else if (state == ARB && enable_arb && pick_valid) begin
            grant  <= pick;
            rr_ptr <= IW'((int'(pick) + 1) % NUM_SRC);
        end
    end

    // Single output register stage; fields only change when the slot is free
    always_ff @(posedge axi_tclk or negedge axi_tresetn) begin
        if (!axi_tresetn) begin
            m_axis_tvalid <= 1'b0;
            m_axis_tdata  <= '0;
            m_axis_tuser  <= '0;
            m_axis_tlast  <= 1'b0;
            m_axis_tdest  <= '0;
            timeout_pulse <= 1'b0;
        end else begin
            timeout_pulse <= timeout_fire;
            if (xfer_accept) begin
                m_axis_tvalid <= 1'b1;
                m_axis_tdata  <= g_data;
                m_axis_tuser  <= g_user;
                m_axis_tlast  <= g_last;
                m_axis_tdest  <= 4'(grant);
            end else if (timeout_fire) begin
                m_axis_tvalid <= 1'b1;
                m_axis_tdata  <= ERR_WORD;
                m_axis_tuser  <= g_user;
                m_axis_tlast  <= 1'b1;
                m_axis_tdest  <= 4'(grant);
            end else if (m_axis_tready) begin
                m_axis_tvalid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_axi_rsp_arbiter.sv
// Scoreboard bench for axi_rsp_arbiter: queued sources, round-robin reference model, output monitor.
`timescale 1ns/1ps
module tb_axi_rsp_arbiter;

    localparam int          NUM_SRC        = 4;
    localparam int          TIMEOUT_CYCLES = 16;
    localparam logic [31:0] ERR_WORD       = 32'h45525252;
`ifdef RSP_TIMEOUT_EN
    localparam int EXP_PULSES = 1;
`else
    localparam int EXP_PULSES = 0;
`endif

    logic                  axi_tclk = 1'b0;
    logic                  axi_tresetn;
    logic                  enable_arb;
    logic [NUM_SRC*32-1:0] s_axis_tdata;
    logic [NUM_SRC*32-1:0] s_axis_tuser;
    logic [NUM_SRC-1:0]    s_axis_tvalid;
    logic [NUM_SRC-1:0]    s_axis_tlast;
    logic [NUM_SRC-1:0]    s_axis_tready;
    logic [31:0]           m_axis_tdata;
    logic [31:0]           m_axis_tuser;
    logic                  m_axis_tvalid;
    logic                  m_axis_tlast;
    logic [3:0]            m_axis_tdest;
    logic                  m_axis_tready;
    logic [2:0]            grant_idx;
    logic                  busy;
    logic                  timeout_pulse;

    axi_rsp_arbiter #(.NUM_SRC(NUM_SRC), .TIMEOUT_CYCLES(TIMEOUT_CYCLES)) dut (
        .axi_tclk(axi_tclk), .axi_tresetn(axi_tresetn), .enable_arb(enable_arb),
        .s_axis_tdata(s_axis_tdata), .s_axis_tuser(s_axis_tuser),
        .s_axis_tvalid(s_axis_tvalid), .s_axis_tlast(s_axis_tlast), .s_axis_tready(s_axis_tready),
        .m_axis_tdata(m_axis_tdata), .m_axis_tuser(m_axis_tuser), .m_axis_tvalid(m_axis_tvalid),
        .m_axis_tlast(m_axis_tlast), .m_axis_tdest(m_axis_tdest), .m_axis_tready(m_axis_tready),
        .grant_idx(grant_idx), .busy(busy), .timeout_pulse(timeout_pulse)
    );

    always #5 axi_tclk = ~axi_tclk;

    typedef struct packed {logic [31:0] data; logic [31:0] user; logic last;} beat_t;
    typedef struct packed {logic [3:0] dest; logic [31:0] data; logic [31:0] user; logic last;} obs_t;

    beat_t src_q[NUM_SRC][$];
    beat_t mdl_q[NUM_SRC][$];
    obs_t  exp_q[$];
    int    beat_cyc[$];
    int    hold_after[NUM_SRC];
    int    sent_cnt[NUM_SRC];
    int    checks = 0, failures = 0;
    int    model_ptr = 0, out_count = 0, pulse_cnt = 0, cyc = 0, ready_mode = 0;

    always @(posedge axi_tclk) cyc <= cyc + 1;

    task automatic checkEq(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge axi_tclk);
            #2;
        end
    endtask

    task automatic driveSources();
        for (int i = 0; i < NUM_SRC; i++) begin
            if (src_q[i].size() > 0 && !(hold_after[i] >= 0 && sent_cnt[i] >= hold_after[i])) begin
                s_axis_tvalid[i]         = 1'b1;
                s_axis_tdata[i*32 +: 32] = src_q[i][0].data;
                s_axis_tuser[i*32 +: 32] = src_q[i][0].user;
                s_axis_tlast[i]          = src_q[i][0].last;
            end else begin
                s_axis_tvalid[i]         = 1'b0;
                s_axis_tdata[i*32 +: 32] = '0;
                s_axis_tuser[i*32 +: 32] = '0;
                s_axis_tlast[i]          = 1'b0;
            end
        end
    endtask

    // Queue one packet on a source; the command ID is constant within the packet
    task automatic applyStimulus(input int src, input int len, input bit to_model);
        beat_t b;
        logic [31:0] user;
        user = $urandom;
        for (int j = 0; j < len; j++) begin
            b.data = $urandom;
            b.user = user;
            b.last = (j == len - 1);
            src_q[src].push_back(b);
            if (to_model) mdl_q[src].push_back(b);
        end
    endtask

    // Reference: each grant goes to the first source holding a packet, searching from the pointer
    task automatic predict(input int npk);
        int    s;
        beat_t b;
        for (int p = 0; p < npk; p++) begin
            s = -1;
            for (int k = 0; k < NUM_SRC; k++)
                if (s < 0 && mdl_q[(model_ptr + k) % NUM_SRC].size() > 0) s = (model_ptr + k) % NUM_SRC;
            if (s >= 0) begin
                model_ptr = (s + 1) % NUM_SRC;
                do begin
                    b = mdl_q[s].pop_front();
                    exp_q.push_back(obs_t'({4'(s), b.data, b.user, b.last}));
                end while (!b.last);
            end
        end
    endtask

    task automatic checkOutput();
        obs_t got, exp;
        got = {m_axis_tdest, m_axis_tdata, m_axis_tuser, m_axis_tlast};
        checks++;
        out_count++;
        beat_cyc.push_back(cyc);
        if (exp_q.size() == 0) begin
            failures++;
            $display("[TB] FAIL beat: got dest=%0d data=%h last=%0d expected no beat", got.dest, got.data, got.last);
        end else begin
            exp = exp_q.pop_front();
            if (got !== exp) begin
                failures++;
                $display("[TB] FAIL beat: got dest=%0d data=%h user=%h last=%0d expected dest=%0d data=%h user=%h last=%0d",
                         got.dest, got.data, got.user, got.last, exp.dest, exp.data, exp.user, exp.last);
            end
        end
    endtask

    task automatic checkResetZero(input string name);
        checkEq({name, "_payload"}, {m_axis_tdata, m_axis_tuser}, 64'd0);
        checkEq({name, "_ctrl"}, {m_axis_tvalid, m_axis_tlast, m_axis_tdest, s_axis_tready,
                                  grant_idx, busy, timeout_pulse}, 64'd0);
    endtask

    task automatic waitDone(input string name, input int budget);
        int n = 0;
        while ((exp_q.size() != 0 || busy) && n < budget) begin
            tick();
            n++;
        end
        checkEq({name, "_done_in_budget"}, 64'(n < budget), 64'd1);
    endtask

    task automatic waitExp(input string name, input int budget);
        int n = 0;
        while (exp_q.size() != 0 && n < budget) begin
            tick();
            n++;
        end
        checkEq({name, "_beats_in_budget"}, 64'(n < budget), 64'd1);
    endtask

    task automatic waitBeats(input int target, input int budget);
        int n = 0;
        while (out_count < target && n < budget) begin
            tick();
            n++;
        end
        checkEq("beat_wait_in_budget", 64'(n < budget), 64'd1);
    endtask

    initial begin : src_driver
        logic [NUM_SRC-1:0] hs;
        for (int i = 0; i < NUM_SRC; i++) begin
            hold_after[i] = -1;
            sent_cnt[i]   = 0;
        end
        forever begin
            @(negedge axi_tclk);
            hs = s_axis_tvalid & s_axis_tready;
            @(posedge axi_tclk);
            #1;
            for (int i = 0; i < NUM_SRC; i++)
                if (hs[i] && src_q[i].size() > 0) begin
                    void'(src_q[i].pop_front());
                    sent_cnt[i]++;
                end
            driveSources();
            case (ready_mode)
                0:       m_axis_tready = 1'b1;
                1:       m_axis_tready = !m_axis_tready;
                default: m_axis_tready = ($urandom_range(0, 3) != 0);
            endcase
        end
    end

    initial begin : monitor
        obs_t prev, cur;
        logic prev_stall;
        prev_stall = 1'b0;
        prev       = '0;
        forever begin
            @(negedge axi_tclk);
            cur = {m_axis_tdest, m_axis_tdata, m_axis_tuser, m_axis_tlast};
            if (!axi_tresetn) begin
                prev_stall = 1'b0;
            end else begin
                if (prev_stall) begin
                    checks++;
                    if (!m_axis_tvalid || cur !== prev) begin
                        failures++;
                        $display("[TB] FAIL stall_hold: got valid=%0d data=%h expected valid=1 data=%h",
                                 m_axis_tvalid, cur.data, prev.data);
                    end
                end
                if (timeout_pulse) begin
                    pulse_cnt++;
                    checks++;
                    if (!(m_axis_tvalid && m_axis_tdata == ERR_WORD && m_axis_tlast)) begin
                        failures++;
                        $display("[TB] FAIL pulse_with_err_beat: got valid=%0d data=%h last=%0d expected 1/%h/1",
                                 m_axis_tvalid, m_axis_tdata, m_axis_tlast, ERR_WORD);
                    end
                end
                if (m_axis_tvalid && m_axis_tready) checkOutput();
                prev_stall = m_axis_tvalid && !m_axis_tready;
                prev       = cur;
            end
        end
    end

    initial begin : watchdog
        #600000;
        $display("[TB] FAIL global_timeout: got no finish expected finish within budget");
        $fatal(1, "[TB] simulation time limit exceeded");
    end

    initial begin : main
        int base, s0, npk;
        axi_tresetn   = 1'b0;
        enable_arb    = 1'b0;
        s_axis_tdata  = '0;
        s_axis_tuser  = '0;
        s_axis_tvalid = '0;
        s_axis_tlast  = '0;
        m_axis_tready = 1'b1;
        #12;
        checkResetZero("reset_init");
        @(negedge axi_tclk);
        axi_tresetn = 1'b1;
        tick(2);

        $display("[TB] four sources, three beats each");
        for (int s = 0; s < NUM_SRC; s++) applyStimulus(s, 3, 1);
        predict(4);
        base = out_count;
        tick();
        enable_arb = 1'b1;
        waitDone("rr_four", 200);
        checkEq("rr_beat_count", 64'(out_count - base), 64'd12);
        if (out_count - base >= 12)
            checkEq("rr_span_cycles", 64'(beat_cyc[base + 11] - beat_cyc[base]), 64'd14);

        $display("[TB] late requesters after grant of source 2");
        applyStimulus(2, 6, 1);
        predict(1);
        base = out_count;
        waitBeats(base + 1, 50);
        applyStimulus(1, 3, 1);
        applyStimulus(3, 3, 1);
        predict(2);
        waitDone("rr_after_2", 200);

        $display("[TB] toggling host ready");
        ready_mode = 1;
        applyStimulus(0, 4, 1);
        predict(1);
        waitDone("toggle_ready", 100);
        ready_mode = 0;
        tick(2);

        $display("[TB] enable drop mid-packet");
        enable_arb = 1'b0;
        s0 = model_ptr;
        applyStimulus(s0, 4, 1);
        applyStimulus(s0, 2, 1);
        applyStimulus((s0 + 1) % NUM_SRC, 3, 1);
        predict(1);
        base = out_count;
        tick();
        enable_arb = 1'b1;
        waitBeats(base + 2, 50);
        enable_arb = 1'b0;
        waitDone("en_drop", 100);
        tick(3);
        checkEq("en_drop_beats", 64'(out_count - base), 64'd4);
        checkEq("en_drop_busy", 64'(busy), 64'd0);
        checkEq("en_drop_still_requesting", 64'(|s_axis_tvalid), 64'd1);
        enable_arb = 1'b1;
        predict(2);
        waitDone("en_restore", 100);

        $display("[TB] randomized packets with random backpressure");
        ready_mode = 2;
        repeat (6) begin
            enable_arb = 1'b0;
            npk = 0;
            for (int s = 0; s < NUM_SRC; s++) begin
                int n = $urandom_range(0, 2);
                for (int p = 0; p < n; p++) begin
                    applyStimulus(s, $urandom_range(1, 4), 1);
                    npk++;
                end
            end
            predict(npk);
            tick();
            enable_arb = 1'b1;
            waitDone("random", 400);
        end
        ready_mode = 0;
        tick(2);

`ifdef RSP_TIMEOUT_EN
        $display("[TB] watchdog on stalled source 1");
        sent_cnt[1]   = 0;
        hold_after[1] = 2;
        applyStimulus(1, 5, 0);
        exp_q.push_back(obs_t'({4'd1, src_q[1][0].data, src_q[1][0].user, 1'b0}));
        exp_q.push_back(obs_t'({4'd1, src_q[1][1].data, src_q[1][1].user, 1'b0}));
        exp_q.push_back(obs_t'({4'd1, ERR_WORD, src_q[1][0].user, 1'b1}));
        model_ptr = 2;
        waitExp("timeout_err", 200);
        checkEq("timeout_busy_in_flush", 64'(busy), 64'd1);
        hold_after[1] = -1;
        waitDone("flush", 100);
        checkEq("flush_drained", 64'(src_q[1].size()), 64'd0);
`endif

        $display("[TB] reset mid-packet");
        applyStimulus(2, 8, 1);
        predict(1);
        base = out_count;
        waitBeats(base + 2, 50);
        axi_tresetn = 1'b0;
        #1;
        checkResetZero("reset_mid");
        for (int s = 0; s < NUM_SRC; s++) begin
            src_q[s].delete();
            mdl_q[s].delete();
        end
        exp_q.delete();
        model_ptr  = 0;
        enable_arb = 1'b0;
        tick(2);
        @(negedge axi_tclk);
        axi_tresetn = 1'b1;
        tick(2);
        applyStimulus(1, 3, 1);
        applyStimulus(3, 3, 1);
        predict(2);
        tick();
        enable_arb = 1'b1;
        waitDone("post_reset", 100);

        checkEq("timeout_pulse_count", 64'(pulse_cnt), 64'(EXP_PULSES));
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
